serial_adder_n: RTL

Parametrised bit-serial adder/subtractor. It extends the team's single-bit full-adder cell to WIDTH-bit operands by reusing one full-adder slice over WIDTH clock cycles, with a registered carry. A start/done handshake hands operands in and results out. It sits beside the combinational adders in the arithmetic lab set and is the first sequential member of that family.

---
 rtl/serial_adder_n_if.sv | 26 ++
 rtl/serial_adder_n.sv | 112 +++++++++++
 2 files changed

// File: rtl/serial_adder_n_if.sv
// rtl/serial_adder_n_if.sv - start/done operand and result bundle for serial_adder_n
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  ready, busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output ready, busy, done, s, cout, ovf
  );
endinterface

// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - bit-serial adder/subtractor, one full-adder slice reused over WIDTH cycles
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  serial_adder_n_if.slave io_bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_cout;
  logic             r_ovf;

  logic w_sum;
  logic w_carry;
  logic w_last;
  logic w_ready;
  logic w_busy;
  logic w_done;

  assign w_sum   = r_a[0] ^ r_b[0] ^ r_c;
  assign w_carry = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (io_bus.start) w_next = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // On the last RUN cycle r_a[0]/r_b[0] are the operand MSBs (B already inverted for sub).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_s    <= '0;
      r_cnt  <= '0;
      r_c    <= 1'b0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_a   <= io_bus.a;
            r_b   <= io_bus.sub ? ~io_bus.b : io_bus.b;
            r_c   <= io_bus.sub | io_bus.cin;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_s   <= {w_sum, r_s[WIDTH-1:1]};
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_c   <= w_carry;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout <= w_carry;
            r_ovf  <= (r_a[0] == r_b[0]) && (w_sum != r_a[0]);
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.ready = w_ready;
  assign io_bus.busy  = w_busy;
  assign io_bus.done  = w_done;
  assign io_bus.s     = r_s;
  assign io_bus.cout  = r_cout;
  assign io_bus.ovf   = r_ovf;

endmodule
